vect_pipe: RTL and testbench

VECT_PIPE -- requirements
Module: vect_pipe

---
 rtl/vect_pipe.sv | 69 ++++++
 tb/tb_vect_pipe.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/vect_pipe.sv
// vect_pipe: DEPTH-stage bubble-collapsing vector pipeline; in_valid/in_ready/in_vect/in_mask in, out_valid/out_ready/out_vect/out_mask out, flush discards, count = occupied stages
module vect_pipe #(
  parameter int WIDTH = 43,
  parameter int N_EL = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_EL*WIDTH-1:0]        in_vect,
  input  logic [N_EL-1:0]              in_mask,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N_EL*WIDTH-1:0]        out_vect,
  output logic [N_EL-1:0]              out_mask,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int DW = N_EL * WIDTH;
  localparam int CW = $clog2(DEPTH + 1);
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] ready;
  logic [DW-1:0] data [DEPTH];
  logic [N_EL-1:0] mask [DEPTH];
  logic [DW-1:0] in_masked;
  logic accept, emit;
  for (genvar i = 0; i < N_EL; i++) begin : g_lane
    assign in_masked[i*WIDTH +: WIDTH] = in_mask[i] ? in_vect[i*WIDTH +: WIDTH] : '0;
  end
  for (genvar k = 0; k < DEPTH; k++) begin : g_ready
    assign ready[k] = out_ready | ~&valid[DEPTH-1:k];
  end
  assign in_ready = ready[0];
  assign accept = in_valid & in_ready;
  assign emit = valid[DEPTH-1] & out_ready;
  assign out_valid = valid[DEPTH-1];
  assign out_vect = data[DEPTH-1];
  assign out_mask = mask[DEPTH-1];
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      count <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data[k] <= '0;
        mask[k] <= '0;
      end
    end else begin
      if (ready[0]) valid[0] <= in_valid;
      if (accept) begin
        data[0] <= in_masked;
        mask[0] <= in_mask;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (ready[k]) begin
          valid[k] <= valid[k-1];
          if (valid[k-1]) begin
            data[k] <= data[k-1];
            mask[k] <= mask[k-1];
          end
        end
      end
      if (flush) valid <= '0;
      if (flush) count <= '0;
      else if (accept & ~emit) count <= count + CW'(1);
      else if (emit & ~accept) count <= count - CW'(1);
    end
  end
endmodule

// File: tb/tb_vect_pipe.sv
// tb_vect_pipe: directed and randomized checks of vect_pipe against a queue-based reference model
module tb_vect_pipe;
  localparam int W = 8;
  localparam int N = 4;
  localparam int D = 2;
  typedef struct {
    logic [31:0] v;
    logic [3:0] m;
    int t;
  } item_t;
  logic clk = 1'b0;
  logic rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_vect, out_vect;
  logic [3:0] in_mask, out_mask;
  logic [1:0] count;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  vect_pipe #(.WIDTH(W), .N_EL(N), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_vect(in_vect), .in_mask(in_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_vect(out_vect), .out_mask(out_mask),
    .count(count)
  );
  function automatic logic [31:0] masked(input logic [31:0] v, input logic [3:0] m);
    logic [31:0] r;
    for (int i = 0; i < N; i++) r[8*i +: 8] = m[i] ? v[8*i +: 8] : 8'h00;
    return r;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic iv, input logic [31:0] v, input logic [3:0] m, input logic ordy, input logic fl);
    in_valid = iv;
    in_vect = v;
    in_mask = m;
    out_ready = ordy;
    flush = fl;
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick;
    tick;
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (count !== 2'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_vect !== 32'h0) begin failures++; $display("FAIL reset_out_vect got=%h exp=0", out_vect); end
    checks++; if (out_mask !== 4'h0) begin failures++; $display("FAIL reset_out_mask got=%h exp=0", out_mask); end
  endtask
  task automatic test_streaming;
    logic [31:0] v [3];
    v[0] = 32'h04030201;
    v[1] = 32'h08070605;
    v[2] = 32'h0C0B0A09;
    for (int c = 0; c < 6; c++) begin
      if (c < 3) drive(1, v[c], 4'hF, 1, 0);
      else drive(0, 0, 0, 1, 0);
      if (c < 3) begin
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready c=%0d got=%b exp=1", c, in_ready); end
      end
      if (c < 2 || c == 5) begin
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_out_valid c=%0d got=%b exp=0", c, out_valid); end
      end else begin
        checks++; if (out_valid !== 1'b1 || out_vect !== v[c-2]) begin failures++; $display("FAIL stream_out c=%0d got=%b/%h exp=1/%h", c, out_valid, out_vect, v[c-2]); end
      end
      if (c == 2 || c == 3) begin
        checks++; if (count !== 2'd2) begin failures++; $display("FAIL stream_count c=%0d got=%0d exp=2", c, count); end
      end
      tick;
    end
  endtask
  task automatic test_masking;
    drive(1, 32'hDDCCBBAA, 4'b0101, 1, 0);
    tick;
    drive(0, 0, 0, 1, 0);
    tick;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mask_out_valid got=%b exp=1", out_valid); end
    checks++; if (out_vect !== 32'h00CC00AA) begin failures++; $display("FAIL mask_out_vect got=%h exp=00cc00aa", out_vect); end
    checks++; if (out_mask !== 4'b0101) begin failures++; $display("FAIL mask_out_mask got=%b exp=0101", out_mask); end
    tick;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mask_drain got=%b exp=0", out_valid); end
  endtask
  task automatic test_backpressure;
    logic [31:0] a, b, c;
    a = 32'h11223344;
    b = 32'h55667788;
    c = 32'h99AABBCC;
    drive(1, a, 4'hF, 0, 0);
    tick;
    drive(1, b, 4'hF, 0, 0);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_second_ready got=%b exp=1", in_ready); end
    tick;
    for (int r = 0; r < 2; r++) begin
      drive(1, c, 4'hF, 0, 0);
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready r=%0d got=%b exp=0", r, in_ready); end
      checks++; if (count !== 2'd2) begin failures++; $display("FAIL bp_full_count r=%0d got=%0d exp=2", r, count); end
      checks++; if (out_valid !== 1'b1 || out_vect !== a) begin failures++; $display("FAIL bp_hold r=%0d got=%b/%h exp=1/%h", r, out_valid, out_vect, a); end
      tick;
    end
    drive(1, c, 4'hF, 1, 0);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    checks++; if (out_vect !== a) begin failures++; $display("FAIL bp_first got=%h exp=%h", out_vect, a); end
    tick;
    drive(0, 0, 0, 1, 0);
    checks++; if (out_valid !== 1'b1 || out_vect !== b || count !== 2'd2) begin failures++; $display("FAIL bp_second got=%b/%h/%0d exp=1/%h/2", out_valid, out_vect, count, b); end
    tick;
    checks++; if (out_valid !== 1'b1 || out_vect !== c || count !== 2'd1) begin failures++; $display("FAIL bp_third got=%b/%h/%0d exp=1/%h/1", out_valid, out_vect, count, c); end
    tick;
    checks++; if (out_valid !== 1'b0 || count !== 2'd0) begin failures++; $display("FAIL bp_empty got=%b/%0d exp=0/0", out_valid, count); end
  endtask
  task automatic test_flush;
    drive(1, 32'h01010101, 4'hF, 0, 0);
    tick;
    drive(1, 32'h02020202, 4'hF, 0, 0);
    tick;
    drive(1, 32'hDEADBEEF, 4'hF, 1, 1);
    checks++; if (count !== 2'd2) begin failures++; $display("FAIL flush_pre_count got=%0d exp=2", count); end
    tick;
    drive(0, 0, 0, 1, 0);
    checks++; if (out_valid !== 1'b0 || count !== 2'd0) begin failures++; $display("FAIL flush_after got=%b/%0d exp=0/0", out_valid, count); end
    for (int r = 0; r < 4; r++) begin
      tick;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_leak r=%0d got=%b/%h exp=0", r, out_valid, out_vect); end
    end
  endtask
  task automatic test_reset_mid;
    drive(1, 32'hA5A5A5A5, 4'hF, 0, 0);
    tick;
    drive(1, 32'h5A5A5A5A, 4'hF, 0, 0);
    tick;
    drive(1, 32'h12345678, 4'hF, 0, 1);
    checks++; if (count !== 2'd2) begin failures++; $display("FAIL rstmid_pre_count got=%0d exp=2", count); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    drive(0, 0, 0, 1, 0);
    checks++; if (out_valid !== 1'b0 || count !== 2'd0) begin failures++; $display("FAIL rstmid_state got=%b/%0d exp=0/0", out_valid, count); end
    checks++; if (out_vect !== 32'h0 || out_mask !== 4'h0) begin failures++; $display("FAIL rstmid_data got=%h/%h exp=0/0", out_vect, out_mask); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b exp=1", in_ready); end
    for (int r = 0; r < 3; r++) begin
      tick;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_leak r=%0d got=%b exp=0", r, out_valid); end
    end
  endtask
  task automatic test_random;
    item_t q [$];
    int cyc;
    logic iv, ordy, fl, exp_ir, exp_ov, stall;
    logic [31:0] v, hv;
    logic [3:0] m, hm;
    cyc = 0;
    stall = 1'b0;
    hv = '0;
    hm = '0;
    for (int n = 0; n < 800; n++) begin
      iv = $urandom_range(0, 3) != 0;
      ordy = $urandom_range(0, 2) != 0;
      fl = $urandom_range(0, 39) == 0;
      v = $urandom;
      m = 4'($urandom);
      drive(iv, v, m, ordy, fl);
      exp_ir = (q.size() < D) || ordy;
      exp_ov = (q.size() > 0) && ((cyc - q[0].t) >= D);
      checks++; if (in_ready !== exp_ir) begin failures++; $display("FAIL rand_in_ready n=%0d got=%b exp=%b", n, in_ready, exp_ir); end
      checks++; if (out_valid !== exp_ov) begin failures++; $display("FAIL rand_out_valid n=%0d got=%b exp=%b", n, out_valid, exp_ov); end
      checks++; if (count !== 2'(q.size())) begin failures++; $display("FAIL rand_count n=%0d got=%0d exp=%0d", n, count, q.size()); end
      if (exp_ov) begin
        checks++; if (out_vect !== q[0].v || out_mask !== q[0].m) begin failures++; $display("FAIL rand_data n=%0d got=%h/%h exp=%h/%h", n, out_vect, out_mask, q[0].v, q[0].m); end
      end
      if (stall) begin
        checks++; if (out_valid !== 1'b1 || out_vect !== hv || out_mask !== hm) begin failures++; $display("FAIL rand_hold n=%0d got=%b/%h/%h exp=1/%h/%h", n, out_valid, out_vect, out_mask, hv, hm); end
      end
      stall = exp_ov && !ordy && !fl;
      if (exp_ov) begin
        hv = q[0].v;
        hm = q[0].m;
      end
      if (exp_ov && ordy) void'(q.pop_front());
      if (fl) q.delete();
      else if (iv && exp_ir) q.push_back('{masked(v, m), m, cyc});
      tick;
      cyc++;
    end
  endtask
  initial begin
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_vect = '0;
    in_mask = '0;
    out_ready = 1'b0;
    test_reset;
    test_streaming;
    test_masking;
    test_backpressure;
    test_flush;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
